mem_arbiter: RTL and testbench
==============================

MEM_ARBITER -- requirements
Module: mem_arbiter

Interface
REQ-001 SHALL have parameter DATA_W, default 32, meaning the data and address width in bits.
REQ-002 SHALL have parameter DEPTH, default 512, meaning the number of RAM words; addresses >= DEPTH are out of range.
REQ-003 SHALL have port clk, input, 1 bit: the single clock; all state updates on its rising edge.
REQ-004 SHALL have port clr, input, 1 bit: reset, synchronous and active-high.
REQ-005 SHALL have ports f_req (input, 1), f_addr (input, DATA_W) and f_ack (output, 1): the fetch port, which is read-only.
REQ-006 SHALL have ports d_req (input, 1), d_we (input, 1), d_addr (input, DATA_W), d_wdata (input, DATA_W) and d_ack (output, 1): the load/store port.
REQ-007 SHALL have ports rdata (output, DATA_W) and err (output, 1): the response data and the out-of-range flag, both shared by the two ports.
REQ-008 SHALL have ports m_addr (output, DATA_W), m_din (output, DATA_W), m_read (output, 1) and m_write (output, 1) driving the RAM, and m_dout (input, DATA_W), the RAM's combinational read data.

Function
REQ-009 SHALL implement FSM states IDLE, ACCESS and RESP; reset state is IDLE.
REQ-010 IDLE: if any req is high, SHALL latch the winner's id, address, we and wdata, then go to ACCESS; otherwise stay in IDLE.
REQ-011 Arbitration SHALL be round-robin: with both requesting, the grant goes to the port not granted last; after reset the last-granted pointer indicates data, so fetch wins the first tie.
REQ-012 If only one port is requesting, SHALL grant that port regardless of the pointer; the pointer updates only on a grant.
REQ-013 ACCESS, in range, read: SHALL drive m_read=1 and m_addr=latched address for exactly one cycle and register m_dout into rdata at the cycle's end.
REQ-014 ACCESS, in range, write: SHALL drive m_write=1, m_addr and m_din=latched wdata for exactly one cycle; rdata is set to 0.
REQ-015 ACCESS, out of range: SHALL leave m_read and m_write at 0, set rdata to 0 and set err to 1.
REQ-016 ACCESS SHALL always go to RESP.
REQ-017 RESP: SHALL pulse the granted port's ack for exactly one cycle, with rdata and err valid in that same cycle, then go to IDLE.
REQ-018 Latency SHALL be: req sampled in IDLE at cycle N, RAM strobe at N+1, ack at N+2; at most one transaction completes every 3 cycles.
REQ-019 f_ack and d_ack SHALL never be high in the same cycle, and m_read and m_write SHALL never be high in the same cycle.
REQ-020 Requester inputs sampled after IDLE SHALL be ignored; dropping req mid-transaction SHALL NOT abort it, and the ack still pulses.
REQ-021 A requester holding req high through its ack SHALL be treated as a new request in the next IDLE cycle, subject to round-robin.
REQ-022 Outside ACCESS, m_read, m_write, m_addr and m_din SHALL be 0.
REQ-023 rdata and err SHALL hold their values until the next ACCESS.
REQ-024 The fetch port SHALL always be a read; a fetch can never cause a write.

Reset
REQ-025 clr=1 at a clock edge SHALL force: state IDLE; f_ack, d_ack, err, m_read and m_write to 0; rdata, m_addr and m_din to 0; pointer to data.
REQ-026 clr asserted in ACCESS or RESP SHALL abort the transaction: no ack issued, and no RAM strobe in the following cycle.
REQ-027 clr SHALL take precedence over all requests in the same cycle.

Verification
REQ-028 Fetch read: RAM[0]=0x0B00002B, f_req=1 with f_addr=0 -> m_read high 1 cycle later, f_ack with rdata=0x0B00002B 2 cycles after the request, err=0.
REQ-029 Store then load: d_req with d_we=1, d_addr=0x87, d_wdata=0x55 -> m_write with m_addr=0x87 and m_din=0x55, then d_ack; a following load from 0x87 -> rdata=0x55.
REQ-030 Contention after reset: f_req and d_req both held high -> acks in order f, d, f, d at cycles 2, 5, 8, 11.
REQ-031 Out of range: d_req with d_we=1 and d_addr=512 -> m_write never asserts, d_ack with err=1 and rdata=0, RAM unchanged.
REQ-032 Reset mid-op: clr=1 during ACCESS of a fetch -> no f_ack, all outputs 0 next cycle, next request serviced normally.
REQ-033 Early release: f_req dropped the cycle after grant -> f_ack still pulses at N+2, and no second transaction starts.

Source files
------------

// File: rtl/mem_arbiter.sv
// mem_arbiter: two-port round-robin arbiter in front of a single-port RAM.
//
// A read-only fetch port and a load/store port compete for one RAM. Each
// transaction passes through IDLE (arbitrate and latch), ACCESS (one-cycle
// RAM strobe) and RESP (one-cycle ack). The response data and the
// out-of-range flag are shared by both ports and hold until the next ACCESS.
//
// Ports:
//   clk                         single clock, rising edge
//   clr                         synchronous active-high reset
//   f_req, f_addr, f_ack        fetch port (reads only)
//   d_req, d_we, d_addr,
//   d_wdata, d_ack              load/store port
//   rdata, err                  shared response data and out-of-range flag
//   m_addr, m_din,
//   m_read, m_write             RAM control, all registered
//   m_dout                      RAM combinational read data
module mem_arbiter #(
  parameter int DATA_W = 32,
  parameter int DEPTH  = 512
) (
  input  logic              clk,
  input  logic              clr,
  input  logic              f_req,
  input  logic [DATA_W-1:0] f_addr,
  output logic              f_ack,
  input  logic              d_req,
  input  logic              d_we,
  input  logic [DATA_W-1:0] d_addr,
  input  logic [DATA_W-1:0] d_wdata,
  output logic              d_ack,
  output logic [DATA_W-1:0] rdata,
  output logic              err,
  output logic [DATA_W-1:0] m_addr,
  output logic [DATA_W-1:0] m_din,
  output logic              m_read,
  output logic              m_write,
  input  logic [DATA_W-1:0] m_dout
);

  localparam logic [DATA_W-1:0] DEPTH_W = DATA_W'(DEPTH);
  localparam logic [DATA_W-1:0] ZERO_W  = {DATA_W{1'b0}};

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACCESS = 2'd1,
    RESP   = 2'd2
  } state_t;

  state_t            state_r;
  logic              last_d_r;   // 1: data port was granted last
  logic              id_d_r;     // 1: current transaction belongs to data port
  logic [DATA_W-1:0] addr_r;
  logic              we_r;
  logic [DATA_W-1:0] wdata_r;
  logic              oor_r;

  logic              f_ack_r;
  logic              d_ack_r;
  logic [DATA_W-1:0] rdata_r;
  logic              err_r;
  logic [DATA_W-1:0] m_addr_r;
  logic [DATA_W-1:0] m_din_r;
  logic              m_read_r;
  logic              m_write_r;

  logic              grant_f_s;
  logic              grant_d_s;
  logic [DATA_W-1:0] win_addr_s;
  logic              win_we_s;
  logic [DATA_W-1:0] win_wdata_s;
  logic              win_oor_s;

  // Round-robin winner selection and the winner's request fields.
  always_comb begin
    grant_f_s   = 1'b0;
    grant_d_s   = 1'b0;
    win_addr_s  = ZERO_W;
    win_we_s    = 1'b0;
    win_wdata_s = ZERO_W;
    win_oor_s   = 1'b0;
    // Fetch wins when alone, or on a tie when data was served last.
    if (f_req && (!d_req || last_d_r)) begin
      grant_f_s = 1'b1;
    end else if (d_req) begin
      grant_d_s = 1'b1;
    end else begin
      grant_f_s = 1'b0;
      grant_d_s = 1'b0;
    end
    // Fetch is forced to a read; its write-enable and data are tied off.
    if (grant_d_s) begin
      win_addr_s  = d_addr;
      win_we_s    = d_we;
      win_wdata_s = d_wdata;
    end else begin
      win_addr_s  = f_addr;
      win_we_s    = 1'b0;
      win_wdata_s = ZERO_W;
    end
    win_oor_s = (win_addr_s >= DEPTH_W);
  end

  // Transaction FSM with all outputs registered.
  always_ff @(posedge clk) begin
    if (clr) begin
      state_r   <= IDLE;
      last_d_r  <= 1'b1;
      id_d_r    <= 1'b0;
      addr_r    <= ZERO_W;
      we_r      <= 1'b0;
      wdata_r   <= ZERO_W;
      oor_r     <= 1'b0;
      f_ack_r   <= 1'b0;
      d_ack_r   <= 1'b0;
      rdata_r   <= ZERO_W;
      err_r     <= 1'b0;
      m_addr_r  <= ZERO_W;
      m_din_r   <= ZERO_W;
      m_read_r  <= 1'b0;
      m_write_r <= 1'b0;
    end else begin
      case (state_r)
        IDLE: begin
          f_ack_r <= 1'b0;
          d_ack_r <= 1'b0;
          if (grant_f_s || grant_d_s) begin
            id_d_r   <= grant_d_s;
            last_d_r <= grant_d_s;
            addr_r   <= win_addr_s;
            we_r     <= win_we_s;
            wdata_r  <= win_wdata_s;
            oor_r    <= win_oor_s;
            // The RAM strobe is set up here so it is high exactly in ACCESS;
            // out-of-range requests never touch the RAM.
            if (!win_oor_s) begin
              m_read_r  <= !win_we_s;
              m_write_r <= win_we_s;
              m_addr_r  <= win_addr_s;
              m_din_r   <= win_we_s ? win_wdata_s : ZERO_W;
            end else begin
              m_read_r  <= 1'b0;
              m_write_r <= 1'b0;
              m_addr_r  <= ZERO_W;
              m_din_r   <= ZERO_W;
            end
            state_r <= ACCESS;
          end else begin
            state_r <= IDLE;
          end
        end
        ACCESS: begin
          m_read_r  <= 1'b0;
          m_write_r <= 1'b0;
          m_addr_r  <= ZERO_W;
          m_din_r   <= ZERO_W;
          if (oor_r) begin
            rdata_r <= ZERO_W;
            err_r   <= 1'b1;
          end else if (we_r) begin
            rdata_r <= ZERO_W;
            err_r   <= 1'b0;
          end else begin
            rdata_r <= m_dout;
            err_r   <= 1'b0;
          end
          if (id_d_r) begin
            d_ack_r <= 1'b1;
          end else begin
            f_ack_r <= 1'b1;
          end
          state_r <= RESP;
        end
        RESP: begin
          f_ack_r <= 1'b0;
          d_ack_r <= 1'b0;
          state_r <= IDLE;
        end
        default: begin
          f_ack_r   <= 1'b0;
          d_ack_r   <= 1'b0;
          m_read_r  <= 1'b0;
          m_write_r <= 1'b0;
          m_addr_r  <= ZERO_W;
          m_din_r   <= ZERO_W;
          state_r   <= IDLE;
        end
      endcase
    end
  end

  assign f_ack   = f_ack_r;
  assign d_ack   = d_ack_r;
  assign rdata   = rdata_r;
  assign err     = err_r;
  assign m_addr  = m_addr_r;
  assign m_din   = m_din_r;
  assign m_read  = m_read_r;
  assign m_write = m_write_r;

endmodule

// File: tb/tb_mem_arbiter.sv
module tb_mem_arbiter;

  logic        clk = 1'b0;
  logic        clr;
  logic        f_req;
  logic [31:0] f_addr;
  logic        f_ack;
  logic        d_req;
  logic        d_we;
  logic [31:0] d_addr;
  logic [31:0] d_wdata;
  logic        d_ack;
  logic [31:0] rdata;
  logic        err;
  logic [31:0] m_addr;
  logic [31:0] m_din;
  logic        m_read;
  logic        m_write;
  logic [31:0] m_dout;

  logic [31:0] ram [0:511];

  int checks = 0;
  int errors = 0;
  int cyc    = 0;

  typedef struct {
    logic        is_d;
    logic [31:0] rdata;
    logic        err;
    int          cyc;
  } ack_t;

  typedef struct {
    logic        we;
    logic [31:0] addr;
    logic [31:0] din;
    int          cyc;
  } strobe_t;

  ack_t    ack_q[$];
  strobe_t stb_q[$];

  mem_arbiter #(.DATA_W(32), .DEPTH(512)) dut (
    .clk(clk), .clr(clr),
    .f_req(f_req), .f_addr(f_addr), .f_ack(f_ack),
    .d_req(d_req), .d_we(d_we), .d_addr(d_addr), .d_wdata(d_wdata), .d_ack(d_ack),
    .rdata(rdata), .err(err),
    .m_addr(m_addr), .m_din(m_din), .m_read(m_read), .m_write(m_write),
    .m_dout(m_dout)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  // RAM model: combinational read, write on the rising edge.
  assign m_dout = (m_addr < 32'd512) ? ram[m_addr[8:0]] : 32'h0000_0000;
  always @(posedge clk) begin
    if (m_write && (m_addr < 32'd512)) ram[m_addr[8:0]] <= m_din;
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h expected=%h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Monitor: compares every ack and every RAM strobe against the scoreboard.
  always @(negedge clk) begin
    if (f_ack || d_ack) begin
      chk("ack_exclusive", {31'd0, f_ack & d_ack}, 32'd0);
      if (ack_q.size() == 0) begin
        chk("unexpected_ack", 32'd1, 32'd0);
      end else begin
        ack_t e;
        e = ack_q.pop_front();
        chk("ack_port_d", {31'd0, d_ack}, {31'd0, e.is_d});
        chk("ack_cycle", cyc, e.cyc);
        chk("rdata", rdata, e.rdata);
        chk("err", {31'd0, err}, {31'd0, e.err});
      end
    end
    if (m_read || m_write) begin
      chk("strobe_exclusive", {31'd0, m_read & m_write}, 32'd0);
      if (stb_q.size() == 0) begin
        chk("unexpected_strobe", 32'd1, 32'd0);
      end else begin
        strobe_t s;
        s = stb_q.pop_front();
        chk("strobe_write", {31'd0, m_write}, {31'd0, s.we});
        chk("strobe_cycle", cyc, s.cyc);
        chk("m_addr", m_addr, s.addr);
        chk("m_din", m_din, s.din);
      end
    end
  end

  task automatic idle_inputs();
    f_req = 1'b0; f_addr = 32'd0;
    d_req = 1'b0; d_we = 1'b0; d_addr = 32'd0; d_wdata = 32'd0;
  endtask

  task automatic check_all_zero(input string tag);
    chk({tag, "_f_ack"},   {31'd0, f_ack},   32'd0);
    chk({tag, "_d_ack"},   {31'd0, d_ack},   32'd0);
    chk({tag, "_err"},     {31'd0, err},     32'd0);
    chk({tag, "_m_read"},  {31'd0, m_read},  32'd0);
    chk({tag, "_m_write"}, {31'd0, m_write}, 32'd0);
    chk({tag, "_rdata"},   rdata,            32'd0);
    chk({tag, "_m_addr"},  m_addr,           32'd0);
    chk({tag, "_m_din"},   m_din,            32'd0);
  endtask

  task automatic do_reset();
    @(negedge clk);
    idle_inputs();
    clr = 1'b1;
    @(negedge clk);
    @(negedge clk);
    clr = 1'b0;
  endtask

  // One-cycle request pulse; the request is dropped right after the grant.
  task automatic do_req(input logic is_d, input logic we, input logic [31:0] addr,
                        input logic [31:0] wdata, input logic [31:0] exp_rdata,
                        input logic exp_err, input logic exp_strobe);
    int k;
    ack_t a;
    strobe_t s;
    @(negedge clk);
    k = cyc;
    if (is_d) begin
      d_req = 1'b1; d_we = we; d_addr = addr; d_wdata = wdata;
    end else begin
      f_req = 1'b1; f_addr = addr;
    end
    a.is_d = is_d; a.rdata = exp_rdata; a.err = exp_err; a.cyc = k + 2;
    ack_q.push_back(a);
    if (exp_strobe) begin
      s.we = we; s.addr = addr; s.din = we ? wdata : 32'd0; s.cyc = k + 1;
      stb_q.push_back(s);
    end
    @(negedge clk);
    idle_inputs();
    @(negedge clk);
    @(negedge clk);
  endtask

  initial begin
    int k;
    ack_t a;
    strobe_t s;
    for (int i = 0; i < 512; i++) ram[i] = 32'h0000_0000;
    ram[0]   = 32'h0B00_002B;
    ram[1]   = 32'h1111_1111;
    ram[2]   = 32'h2222_2222;
    ram[511] = 32'hA5A5_5A5A;
    clr = 1'b1;
    idle_inputs();
    repeat (3) @(negedge clk);
    check_all_zero("reset");
    clr = 1'b0;

    // Fetch read of word 0.
    do_req(1'b0, 1'b0, 32'd0, 32'd0, 32'h0B00_002B, 1'b0, 1'b1);
    // Store 0x55 to 0x87, then load it back on both ports.
    do_req(1'b1, 1'b1, 32'h87, 32'h55, 32'd0, 1'b0, 1'b1);
    do_req(1'b1, 1'b0, 32'h87, 32'd0, 32'h55, 1'b0, 1'b1);
    do_req(1'b0, 1'b0, 32'h87, 32'd0, 32'h55, 1'b0, 1'b1);
    // Out-of-range store: no RAM strobe, err=1, rdata=0.
    do_req(1'b1, 1'b1, 32'd512, 32'hDEAD_BEEF, 32'd0, 1'b1, 1'b0);
    repeat (4) @(negedge clk);
    chk("err_hold", {31'd0, err}, 32'd1);
    chk("rdata_hold", rdata, 32'd0);
    chk("ram_unchanged", ram[9'h087], 32'h55);
    do_req(1'b1, 1'b0, 32'h87, 32'd0, 32'h55, 1'b0, 1'b1);
    // Out-of-range fetch and the last in-range word.
    do_req(1'b0, 1'b0, 32'hFFFF_FFFF, 32'd0, 32'd0, 1'b1, 1'b0);
    do_req(1'b0, 1'b0, 32'd511, 32'd0, 32'hA5A5_5A5A, 1'b0, 1'b1);

    // Contention after reset: f, d, f, d at k+2, k+5, k+8, k+11.
    do_reset();
    @(negedge clk);
    k = cyc;
    f_req = 1'b1; f_addr = 32'd1;
    d_req = 1'b1; d_we = 1'b0; d_addr = 32'd2;
    for (int i = 0; i < 4; i++) begin
      a.is_d  = (i % 2 == 1);
      a.rdata = a.is_d ? 32'h2222_2222 : 32'h1111_1111;
      a.err   = 1'b0;
      a.cyc   = k + 2 + 3 * i;
      ack_q.push_back(a);
      s.we   = 1'b0;
      s.addr = a.is_d ? 32'd2 : 32'd1;
      s.din  = 32'd0;
      s.cyc  = k + 1 + 3 * i;
      stb_q.push_back(s);
    end
    repeat (11) @(negedge clk);
    idle_inputs();
    repeat (3) @(negedge clk);

    // Reset during ACCESS of a fetch: strobe already out, no ack afterwards.
    @(negedge clk);
    k = cyc;
    f_req = 1'b1; f_addr = 32'd0;
    s.we = 1'b0; s.addr = 32'd0; s.din = 32'd0; s.cyc = k + 1;
    stb_q.push_back(s);
    @(negedge clk);
    idle_inputs();
    clr = 1'b1;
    @(negedge clk);
    check_all_zero("midop");
    clr = 1'b0;
    repeat (4) @(negedge clk);
    do_req(1'b0, 1'b0, 32'd0, 32'd0, 32'h0B00_002B, 1'b0, 1'b1);
    repeat (6) @(negedge clk);

    // Drain with a bounded wait.
    for (int i = 0; i < 50 && (ack_q.size() != 0 || stb_q.size() != 0); i++) @(negedge clk);
    chk("ack_queue_drained", ack_q.size(), 32'd0);
    chk("strobe_queue_drained", stb_q.size(), 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
